// File: rtl/fifo_rd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_engine
//  Description : Burst read engine. On a start request it pops up to
//                burst_len words from a FIFO (one-cycle read latency),
//                buffers them in a 2-entry skid buffer and presents them
//                on a valid/ready stream with a last marker on the final
//                word of the burst. Emits a one-cycle done pulse per burst.
//
//  Ports       : r_clk      - read-domain clock (rising edge)
//                rrst       - synchronous active-high reset
//                start      - burst request, sampled only in IDLE
//                burst_len  - words to drain, latched on accepted start
//                fifo_empty - FIFO empty flag
//                rd_req     - FIFO pop request (combinational)
//                data_out   - FIFO read data, valid 1 cycle after rd_req
//                m_valid    - stream valid
//                m_ready    - stream ready
//                m_data     - stream data
//                m_last     - final word of burst (qualified by m_valid)
//                busy       - engine not idle
//                done       - one-cycle burst-complete pulse
//                rd_count   - words delivered in current/last burst
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  start,
    input  logic [7:0]            burst_len,
    input  logic                  fifo_empty,
    output logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            rd_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [7:0]            r_len;       // latched burst length
    logic [7:0]            r_issued;    // rd_req pulses issued this burst
    logic [7:0]            r_recv;      // words pushed into the buffer this burst
    logic                  r_inflight;  // a FIFO word arrives this cycle
    logic [1:0]            r_occ;       // buffer occupancy (0..2)
    logic [DATA_WIDTH-1:0] r_buf0;      // head entry
    logic [DATA_WIDTH-1:0] r_buf1;      // tail entry
    logic                  r_last0;
    logic                  r_last1;
    logic [8:0]            r_rd_count;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_load;
    logic                  w_rd_req;
    logic                  w_last_in;
    logic                  w_flush_done;
    logic                  w_last_issue;

    assign w_pop  = (r_occ != 2'd0) && m_ready;
    assign w_push = r_inflight;

    // Buffer commitment after this cycle's pop, counting the word already
    // in flight. Credit is taken for a same-cycle pop so that a streaming
    // burst with m_ready held high issues one read every cycle while still
    // guaranteeing a free slot for every outstanding read.
    assign w_load = (r_occ - {1'b0, w_pop}) + {1'b0, r_inflight};

    assign w_rd_req = (r_state == S_DRAIN) && !rrst && !fifo_empty &&
                      (r_issued < r_len) && (w_load < 2'd2);

    assign w_last_issue = w_rd_req && ((r_issued + 8'd1) == r_len);

    // The incoming word is the last of the burst when it is word number r_len.
    assign w_last_in = ((r_recv + 8'd1) == r_len);

    // Buffer drains empty at the end of this cycle with nothing in flight.
    assign w_flush_done = !r_inflight &&
                          ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

    assign rd_req   = w_rd_req;
    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = r_buf0;
    assign m_last   = r_last0 && (r_occ != 2'd0);
    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_count = r_rd_count;

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            r_state    <= S_IDLE;
            r_len      <= 8'd0;
            r_issued   <= 8'd0;
            r_recv     <= 8'd0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_last0    <= 1'b0;
            r_last1    <= 1'b0;
            r_rd_count <= 9'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_rd_req;

            if (w_rd_req) begin
                r_issued <= r_issued + 8'd1;
            end
            if (w_push) begin
                r_recv <= r_recv + 8'd1;
            end
            if (w_pop) begin
                r_rd_count <= r_rd_count + 9'd1;
            end

            // Two-entry FIFO-ordered buffer; head is always r_buf0.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0  <= data_out;
                        r_last0 <= w_last_in;
                    end else begin
                        r_buf1  <= data_out;
                        r_last1 <= w_last_in;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word lands behind any survivor.
                    if (r_occ == 2'd1) begin
                        r_buf0  <= data_out;
                        r_last0 <= w_last_in;
                    end else begin
                        r_buf0  <= r_buf1;
                        r_last0 <= r_last1;
                        r_buf1  <= data_out;
                        r_last1 <= w_last_in;
                    end
                end
                default: begin
                end
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= burst_len;
                        r_issued   <= 8'd0;
                        r_recv     <= 8'd0;
                        r_rd_count <= 9'd0;
                        r_busy     <= 1'b1;
                        if (burst_len == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_issue) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_flush_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_engine
//  Description : Self-checking bench for fifo_rd_engine. A queue models the
//                source FIFO; every popped word is pushed to an expected
//                queue (with its last flag) and compared when the stream
//                handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_engine;

    localparam int DW = 8;

    logic          r_clk;
    logic          rrst;
    logic          start;
    logic [7:0]    burst_len;
    logic          fifo_empty;
    logic          rd_req;
    logic [DW-1:0] data_out;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic [8:0]    rd_count;

    fifo_rd_engine #(.DATA_WIDTH(DW)) u_dut (
        .r_clk      (r_clk),
        .rrst       (rrst),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .rd_req     (rd_req),
        .data_out   (data_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .rd_count   (rd_count)
    );

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    int            n_checks = 0;
    int            n_errors = 0;

    logic [7:0]    fifo_q[$];
    logic [8:0]    exp_q[$];     // {last, data}
    logic          hold_empty;
    logic [DW-1:0] nxt_data;
    int            b_len, b_issued, b_deliv, n_rdreq;
    int            cyc, start_cyc, done_cyc, last_hs, done_cnt;
    logic          prev_stall, prev_rst;
    logic [DW-1:0] prev_data;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        logic [8:0] e;
        logic [7:0] w;
        fifo_empty = hold_empty || (fifo_q.size() == 0);
        data_out   = nxt_data;
        nxt_data   = 8'($urandom);
        #1;
        if (prev_stall && !prev_rst) begin
            chk_eq("hold_valid", 32'(m_valid), 32'd1);
            chk_eq("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (rrst) begin
            chk_eq("rst_rdreq", 32'(rd_req), 32'd0);
        end else begin
            if (rd_req) begin
                n_rdreq++;
                chk_eq("rdreq_limit", 32'(b_issued < b_len), 32'd1);
                chk_eq("rdreq_empty", 32'(fifo_empty), 32'd0);
                if (fifo_q.size() > 0) begin
                    w = fifo_q.pop_front();
                    b_issued++;
                    exp_q.push_back({(b_issued == b_len), w});
                    nxt_data = w;
                end
            end
            if (m_valid && m_ready) begin
                chk_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_eq("m_data", 32'(m_data), 32'(e[7:0]));
                    chk_eq("m_last", 32'(m_last), 32'(e[8]));
                end
                b_deliv++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_rst   = rrst;
        prev_data  = m_data;
        @(negedge r_clk);
        cyc++;
        if (prev_rst) exp_q.delete();
    endtask

    task automatic start_burst(input int len);
        start     = 1'b1;
        burst_len = 8'(len);
        b_len     = len;
        b_issued  = 0;
        b_deliv   = 0;
        n_rdreq   = 0;
        start_cyc = cyc;
        cycle();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (!done) chk_eq({tag, "_busy"}, 32'(busy), 32'd1);
            cycle();
            if (done_cnt != d0) seen = 1;
        end
        chk_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk_eq({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk_eq({tag, "_m_last"}, 32'(m_last), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
        chk_eq({tag, "_done"}, 32'(done), 32'd0);
        chk_eq({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk_eq({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    endtask

    initial begin
        int d0;
        rrst = 1'b1; start = 1'b0; burst_len = 8'd0; m_ready = 1'b1;
        hold_empty = 1'b0; nxt_data = '0; data_out = '0; fifo_empty = 1'b1;
        b_len = 0; b_issued = 0; b_deliv = 0; n_rdreq = 0;
        cyc = 0; start_cyc = 0; done_cyc = 0; last_hs = 0; done_cnt = 0;
        prev_stall = 1'b0; prev_rst = 1'b1; prev_data = '0;
        @(negedge r_clk);

        // Reset, with a start that must be ignored while in reset.
        start = 1'b1; burst_len = 8'd3;
        cycle();
        start = 1'b0;
        cycle();
        rrst = 1'b0;
        #1;
        check_reset_outputs("reset");
        cycle();
        chk_eq("reset_start_ignored", 32'(busy), 32'd0);

        // Four-word streaming burst at full rate.
        fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        m_ready = 1'b1;
        start_burst(4);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_eq("b4_rdreq_consec", 32'(rd_req), 32'd1);
            cycle();
        end
        wait_done("b4");
        chk_eq("b4_done_after_last", 32'(done_cyc - last_hs), 32'd1);
        chk_eq("b4_latency", 32'(done_cyc - start_cyc), 32'd7);
        chk_eq("b4_rd_count", 32'(rd_count), 32'd4);
        chk_eq("b4_sb_empty", 32'(exp_q.size()), 32'd0);
        cycle();
        chk_eq("b4_idle", 32'(busy), 32'd0);

        // Backpressure: only two reads outstanding while stalled.
        fifo_q = '{8'hB1, 8'hB2, 8'hB3};
        m_ready = 1'b0;
        start_burst(3);
        for (int i = 0; i < 5; i++) cycle();
        chk_eq("bp_rdreq_pulses", 32'(n_rdreq), 32'd2);
        chk_eq("bp_head", 32'(m_data), 32'hB1);
        m_ready = 1'b1;
        wait_done("bp");
        chk_eq("bp_rd_count", 32'(rd_count), 32'd3);
        chk_eq("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        cycle();

        // Empty FIFO at start; words appear later.
        fifo_q.delete();
        start_burst(2);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_eq("emp_rdreq_low", 32'(rd_req), 32'd0);
            chk_eq("emp_busy", 32'(busy), 32'd1);
            cycle();
        end
        fifo_q = '{8'hC1, 8'hC2};
        wait_done("emp");
        chk_eq("emp_rd_count", 32'(rd_count), 32'd2);
        cycle();

        // Zero-length burst.
        fifo_q = '{8'hE1};
        start_burst(0);
        #1;
        chk_eq("z_done", 32'(done), 32'd1);
        chk_eq("z_m_valid", 32'(m_valid), 32'd0);
        chk_eq("z_rd_count", 32'(rd_count), 32'd0);
        cycle();
        chk_eq("z_done_once", 32'(done), 32'd0);
        chk_eq("z_no_rdreq", 32'(n_rdreq), 32'd0);
        cycle();
        chk_eq("z_idle", 32'(busy), 32'd0);
        fifo_q.delete();

        // Reset in the middle of a burst.
        fifo_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        start_burst(5);
        for (int i = 0; i < 50 && b_deliv < 2; i++) cycle();
        chk_eq("mr_two_delivered", 32'(b_deliv), 32'd2);
        d0 = done_cnt;
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        #1;
        check_reset_outputs("mr");
        for (int i = 0; i < 5; i++) cycle();
        chk_eq("mr_no_done", 32'(done_cnt - d0), 32'd0);
        fifo_q = '{8'hF1};
        start_burst(1);
        wait_done("mr1");
        chk_eq("mr1_rd_count", 32'(rd_count), 32'd1);
        chk_eq("mr1_sb_empty", 32'(exp_q.size()), 32'd0);
        cycle();

        // start during DRAIN must be ignored.
        fifo_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        d0 = done_cnt;
        start_burst(3);
        cycle();
        start = 1'b1; burst_len = 8'd9;
        cycle();
        start = 1'b0;
        wait_done("ig");
        for (int i = 0; i < 5; i++) cycle();
        chk_eq("ig_done_once", 32'(done_cnt - d0), 32'd1);
        chk_eq("ig_rd_count", 32'(rd_count), 32'd3);
        chk_eq("ig_fifo_left", 32'(fifo_q.size()), 32'd1);
        chk_eq("ig_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
